// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle Moore control unit for the TI170 datapath.
// Sequences fetch, operand load, execute and result store. Every memory access
// waits on a mem_ready handshake, and a stalled access times out into FAULT.
// All control outputs are registered, so each one reflects the current state only.

module control_sequencer #(
    parameter int OPC_W      = 8,
    parameter int ALU_SEL_W  = 4,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [OPC_W-1:0]     IR,
    input  logic                 CCR_Result,
    input  logic                 mem_ready,
    output logic                 IR_Load,
    output logic                 MAR_Load,
    output logic                 MARR_Load,
    output logic                 PC_Load,
    output logic                 PC_Inc,
    output logic                 PR_Inc,
    output logic                 A_Load,
    output logic                 B_Load,
    output logic                 C_Load,
    output logic                 CCR_Load,
    output logic [ALU_SEL_W-1:0] ALU_Sel,
    output logic [1:0]           Bus1_Sel,
    output logic [1:0]           Bus2_Sel,
    output logic                 write,
    output logic                 halted,
    output logic                 fault
);

    localparam int CNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    // Opcodes are zero-extended to the IR width; nonzero upper bits are illegal.
    localparam logic [OPC_W-1:0] OP_INC  = OPC_W'(8'h01);
    localparam logic [OPC_W-1:0] OP_DEC  = OPC_W'(8'h02);
    localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(8'h03);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(8'h04);
    localparam logic [OPC_W-1:0] OP_JC   = OPC_W'(8'h05);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(8'hFF);

    typedef enum logic [4:0] {
        IDLE, F0, F1, FW, F2, DEC,
        A0, A1, AW, A2, BI,
        B0, B1, BW, B2, JP,
        EX, ST0, SW, ST1,
        HALT, FAULT
    } state_t;

    typedef struct packed {
        logic                 irLoad;
        logic                 marLoad;
        logic                 marrLoad;
        logic                 pcLoad;
        logic                 pcInc;
        logic                 prInc;
        logic                 aLoad;
        logic                 bLoad;
        logic                 cLoad;
        logic                 ccrLoad;
        logic [ALU_SEL_W-1:0] aluSel;
        logic [1:0]           bus1Sel;
        logic [1:0]           bus2Sel;
        logic                 write;
        logic                 halted;
        logic                 fault;
    } ctrl_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   waitCnt_q, waitCnt_d;
    ctrl_t              ctrl_q, ctrl_d;

    state_t             waitNext;
    logic               inWait;
    logic               aluOp;
    logic [3:0]         aluCode;

    // Classify the opcode: the ALU ops that take the A-operand path, and their ALU select code.
    always_comb begin
        aluOp   = 1'b1;
        aluCode = 4'h0;
        case (IR)
            OPC_W'(8'h01): aluCode = 4'h0;
            OPC_W'(8'h02): aluCode = 4'h1;
            OPC_W'(8'h03): aluCode = 4'h8;
            OPC_W'(8'h10): aluCode = 4'h0;
            OPC_W'(8'h20): aluCode = 4'h1;
            OPC_W'(8'h30): aluCode = 4'h2;
            OPC_W'(8'h40): aluCode = 4'h3;
            OPC_W'(8'h50): aluCode = 4'h4;
            OPC_W'(8'h60): aluCode = 4'h6;
            OPC_W'(8'h70): aluCode = 4'h7;
            OPC_W'(8'h80): aluCode = 4'hA;
            OPC_W'(8'h90): aluCode = 4'hB;
            OPC_W'(8'hA0): aluCode = 4'hC;
            OPC_W'(8'hB0): aluCode = 4'hD;
            OPC_W'(8'hC0): aluCode = 4'h5;
            default:       aluOp   = 1'b0;
        endcase
    end

    // Next-state logic. Wait states name their exit target, and the shared
    // handshake/timeout handling after the case statement takes it from there.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        waitNext  = state_q;
        inWait    = 1'b0;
        unique case (state_q)
            IDLE:  state_d = F0;
            F0:    state_d = F1;
            F1:    state_d = FW;
            FW:    begin inWait = 1'b1; waitNext = F2; end
            F2:    state_d = DEC;
            DEC: begin
                if (IR == OP_HALT)                   state_d = HALT;
                else if (IR == OP_JMP || IR == OP_JC) state_d = B0;
                else if (aluOp)                      state_d = A0;
                else                                 state_d = FAULT;
            end
            A0:    state_d = A1;
            A1:    state_d = AW;
            AW:    begin inWait = 1'b1; waitNext = A2; end
            A2: begin
                if (IR == OP_NOT)                      state_d = EX;
                else if (IR == OP_INC || IR == OP_DEC) state_d = BI;
                else                                   state_d = B0;
            end
            BI:    state_d = EX;
            B0:    state_d = B1;
            B1:    state_d = BW;
            BW:    begin inWait = 1'b1; waitNext = B2; end
            B2: begin
                if (IR == OP_JMP)     state_d = JP;
                else if (IR == OP_JC) state_d = CCR_Result ? JP : F0;
                else                  state_d = EX;
            end
            JP:    state_d = F0;
            EX:    state_d = ST0;
            ST0:   state_d = SW;
            SW:    begin inWait = 1'b1; waitNext = ST1; end
            ST1:   state_d = F0;
            HALT:  state_d = HALT;
            FAULT: state_d = FAULT;
            default: state_d = FAULT;
        endcase

        if (inWait) begin
            if (mem_ready) begin
                state_d   = waitNext;
                waitCnt_d = '0;
            end else if (WAIT_LIMIT != 0 && waitCnt_q == CNT_W'(WAIT_LIMIT - 1)) begin
                state_d   = FAULT;
                waitCnt_d = '0;
            end else if (WAIT_LIMIT != 0) begin
                waitCnt_d = waitCnt_q + CNT_W'(1);
            end
        end
    end

    // Decode the control word for the state being entered so it lines up with that state.
    always_comb begin
        ctrl_d = '0;
        unique case (state_d)
            F0, A0, B0: ctrl_d.marLoad = 1'b1;
            F1, A1, B1: ctrl_d.pcInc   = 1'b1;
            F2:    begin ctrl_d.irLoad = 1'b1; ctrl_d.bus2Sel = 2'b10; end
            A2:    begin ctrl_d.aLoad  = 1'b1; ctrl_d.bus2Sel = 2'b10; end
            B2:    begin ctrl_d.bLoad  = 1'b1; ctrl_d.bus2Sel = 2'b10; end
            BI:    begin ctrl_d.bLoad  = 1'b1; ctrl_d.bus2Sel = 2'b01; end
            JP:    begin ctrl_d.pcLoad = 1'b1; ctrl_d.bus1Sel = 2'b10; end
            EX: begin
                ctrl_d.cLoad   = 1'b1;
                ctrl_d.ccrLoad = 1'b1;
                ctrl_d.aluSel  = ALU_SEL_W'(aluCode);
            end
            ST0:   begin ctrl_d.marrLoad = 1'b1; ctrl_d.bus1Sel = 2'b11; end
            SW:    ctrl_d.write  = 1'b1;
            ST1:   ctrl_d.prInc  = 1'b1;
            HALT:  ctrl_d.halted = 1'b1;
            FAULT: ctrl_d.fault  = 1'b1;
            default: ctrl_d = '0;
        endcase
    end

    // State, wait counter and control word registers. Reset clears all of them at once, so write drops immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            ctrl_q    <= '0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            ctrl_q    <= ctrl_d;
        end
    end

    assign IR_Load   = ctrl_q.irLoad;
    assign MAR_Load  = ctrl_q.marLoad;
    assign MARR_Load = ctrl_q.marrLoad;
    assign PC_Load   = ctrl_q.pcLoad;
    assign PC_Inc    = ctrl_q.pcInc;
    assign PR_Inc    = ctrl_q.prInc;
    assign A_Load    = ctrl_q.aLoad;
    assign B_Load    = ctrl_q.bLoad;
    assign C_Load    = ctrl_q.cLoad;
    assign CCR_Load  = ctrl_q.ccrLoad;
    assign ALU_Sel   = ctrl_q.aluSel;
    assign Bus1_Sel  = ctrl_q.bus1Sel;
    assign Bus2_Sel  = ctrl_q.bus2Sel;
    assign write     = ctrl_q.write;
    assign halted    = ctrl_q.halted;
    assign fault     = ctrl_q.fault;

endmodule
